encoder4_2_sync: RTL
====================

ENCODER4_2_SYNC -- requirements
Module: encoder4_2_sync

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 3, giving the number of consecutive sampled cycles an input code must hold before it is accepted; legal range 2..15.
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in  input  4  one-hot code to be encoded (the code a 2-to-4 decoder produces).
REQ-006 The block SHALL have port out_ready  input  1  consumer accepts out when it is high together with out_valid.
REQ-007 The block SHALL have port out  output  2  binary index of the accepted one-hot bit.
REQ-008 The block SHALL have port out_valid  output  1  out holds an accepted code.
REQ-009 The block SHALL have port err  output  1  one-cycle pulse flagging a stable non-one-hot, non-zero code.
REQ-010 The block SHALL have port err_count  output  ERR_W  saturating count of err pulses.

Function
REQ-011 The block SHALL implement a 4-state FSM: IDLE, QUAL, PRESENT, WAIT_REL.
REQ-012 In IDLE with in==0, the FSM SHALL stay in IDLE; with in!=0, it SHALL load the candidate register with in, set the stability counter to 1 and go to QUAL.
REQ-013 In QUAL with in==0, the FSM SHALL go to IDLE; with in nonzero but different from the candidate, it SHALL reload the candidate, set the counter to 1 and stay in QUAL.
REQ-014 In QUAL with in==candidate, the counter SHALL increment; when the incremented value equals STABLE_CYCLES the code is accepted, so acceptance occurs at edge k+STABLE_CYCLES-1 after first sampling edge k.
REQ-015 On acceptance of a one-hot candidate, the block SHALL register out = 0,1,2,3 for in = 0001,0010,0100,1000, assert out_valid and go to PRESENT.
REQ-016 On acceptance of a non-one-hot candidate (two or more bits set), the block SHALL pulse err high for exactly one cycle, increment err_count saturating at 2^ERR_W-1, leave out and out_valid unchanged, and go to WAIT_REL.
REQ-017 In PRESENT, out and out_valid SHALL hold stable and in SHALL be ignored until a rising edge with out_ready==1.
REQ-018 At the rising edge with out_ready==1 in PRESENT, out_valid SHALL deassert, out SHALL keep its last value, and the FSM SHALL go to WAIT_REL.
REQ-019 In WAIT_REL, the FSM SHALL go to IDLE at the first edge where in==0 and otherwise stay, so a held code is never reported twice.
REQ-020 out_ready SHALL be ignored outside PRESENT, and out_valid SHALL never assert in any other state.
REQ-021 The minimum round trip SHALL be: accept at edge A, handshake at edge A+1 when out_ready is held high, WAIT_REL, then IDLE one edge after in returns to 0.

Reset
REQ-022 While rst_n==0, the block SHALL force state to IDLE and out=0, out_valid=0, err=0, err_count=0, candidate=0 and counter=0, independent of clk.
REQ-023 Reset asserted mid-operation (in QUAL, PRESENT or WAIT_REL) SHALL discard the pending code with no err pulse and no handshake.
REQ-024 After rst_n rises, the first edge SHALL evaluate as IDLE, so a code already present on in SHALL be qualified afresh.

Verification
REQ-025 Bench SHALL check basic encode: for each in = 1,2,4,8 held 5 cycles with out_ready=1 -> out_valid high for exactly one cycle, out = 0,1,2,3 respectively, err=0.
REQ-026 Bench SHALL check glitch rejection: with STABLE_CYCLES=3, in=4 for 2 cycles then 0 -> out_valid never asserts and err_count stays 0.
REQ-027 Bench SHALL check candidate change: in=2 for 2 cycles then in=8 held -> out=3 accepted 2 edges after the change, with no report of index 1.
REQ-028 Bench SHALL check backpressure: in=1 held, out_ready=0 for 6 cycles while in changes to 2 -> out stays 0 and out_valid stays high; raising out_ready drops out_valid after one edge; no second report until in returns to 0.
REQ-029 Bench SHALL check the error path: in=4'b0110 held 3 cycles -> err high exactly one cycle, err_count goes 0->1, out_valid stays 0; with ERR_W=2, four such events leave err_count at 3.
REQ-030 Bench SHALL check reset mid-operation: rst_n pulled low in PRESENT with out=2 -> out_valid=0 and out=0 immediately without waiting for clk; in=4 held after release -> reported again with out=2.

Source files
------------

// File: rtl/encoder4_2_sync.sv
// Debounced 4-to-2 one-hot encoder with a valid/ready output handshake.
// An input code has to hold for STABLE_CYCLES sampled edges before it is
// accepted. Accepted one-hot codes are presented until the consumer takes
// them. Stable codes with two or more bits set raise a one-cycle err pulse
// and bump a saturating error counter.
module encoder4_2_sync #(
   parameter int unsigned STABLE_CYCLES = 3,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in,
   input  logic             out_ready,
   output logic [1:0]       out,
   output logic             out_valid,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] QUAL     = 2'd1;
   localparam logic [1:0] PRESENT  = 2'd2;
   localparam logic [1:0] WAIT_REL = 2'd3;

   localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [3:0]       stableCnt_q, stableCnt_d;
   logic [1:0]       out_q, out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] errCount_q, errCount_d;

   logic             candOneHot;
   logic [1:0]       candIdx;
   logic [3:0]       cntInc;

   // Classify the held candidate: legal one-hot codes map to their bit index,
   // anything else is flagged as an error code once it proves stable.
   always_comb begin
      candOneHot = 1'b0;
      candIdx    = 2'd0;
      case (cand_q)
         4'b0001: begin candOneHot = 1'b1; candIdx = 2'd0; end
         4'b0010: begin candOneHot = 1'b1; candIdx = 2'd1; end
         4'b0100: begin candOneHot = 1'b1; candIdx = 2'd2; end
         4'b1000: begin candOneHot = 1'b1; candIdx = 2'd3; end
         default: begin candOneHot = 1'b0; candIdx = 2'd0; end
      endcase
   end

   assign cntInc = stableCnt_q + 4'd1;

   // Next-state logic: qualify a code, present or flag it, then wait for the
   // input to return to zero so that a held code is never reported twice.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      stableCnt_d = stableCnt_q;
      out_d       = out_q;
      valid_d     = valid_q;
      err_d       = 1'b0;
      errCount_d  = errCount_q;
      case (state_q)
         IDLE: begin
            if (in != 4'd0) begin
               cand_d      = in;
               stableCnt_d = 4'd1;
               state_d     = QUAL;
            end
         end
         QUAL: begin
            if (in == 4'd0) begin
               stableCnt_d = 4'd0;
               state_d     = IDLE;
            end else if (in != cand_q) begin
               cand_d      = in;
               stableCnt_d = 4'd1;
            end else begin
               stableCnt_d = cntInc;
               if (cntInc == STABLE_LIMIT) begin
                  if (candOneHot) begin
                     out_d   = candIdx;
                     valid_d = 1'b1;
                     state_d = PRESENT;
                  end else begin
                     err_d = 1'b1;
                     if (errCount_q != '1) begin
                        errCount_d = errCount_q + ERR_W'(1);
                     end
                     state_d = WAIT_REL;
                  end
               end
            end
         end
         PRESENT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (in == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything immediately, dropping any
   // pending code without a handshake or error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cand_q      <= 4'd0;
         stableCnt_q <= 4'd0;
         out_q       <= 2'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         errCount_q  <= '0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         stableCnt_q <= stableCnt_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         errCount_q  <= errCount_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign err       = err_q;
   assign err_count = errCount_q;

endmodule
